// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for an in-order pipeline: load-use and mult/div
// interlocks, control-transfer flushes and a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs_ID,
  input  logic [4:0]  Rt_ID,
  input  logic        uses_rt_ID,
  input  logic        MemRead_EX,
  input  logic [4:0]  Rt_EX,
  input  logic        branch_taken_ID,
  input  logic        jump_ID,
  input  logic        md_start_ID,
  input  logic        md_div_ID,
  input  logic        hilo_read_ID,
  output logic        pc_write,
  output logic        stall_IF_ID,
  output logic        flush_IF_ID,
  output logic        flush_ID_EX,
  output logic        md_busy,
  output logic        md_done,
  output logic [15:0] stall_cnt
);

  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_MD_BUSY = 1'b1;

  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES - 1);

  logic [0:0]    r_state;
  logic [CW-1:0] r_md_cnt;
  logic [15:0]   r_stall_cnt;

  logic w_md_busy;
  logic w_md_done;
  logic w_md_stall;
  logic w_lu_stall;
  logic w_stall;

  // Reset masks the interlocks so the pipeline sees a clean flush.
  assign w_md_busy  = ~rst & (r_state == S_MD_BUSY);
  assign w_md_done  = w_md_busy & (r_md_cnt == '0);
  assign w_md_stall = w_md_busy & (hilo_read_ID | md_start_ID);
  assign w_lu_stall = MemRead_EX & (Rt_EX != 5'd0) &
                      ((Rt_EX == Rs_ID) |
                       (uses_rt_ID & (Rt_EX == Rt_ID)));
  assign w_stall    = ~rst & (w_md_stall | w_lu_stall);

  assign pc_write    = ~rst & ~w_stall;
  assign stall_IF_ID = w_stall;
  assign flush_ID_EX = rst | w_stall;
  assign flush_IF_ID = rst |
                       (~w_stall & (branch_taken_ID | jump_ID));
  assign md_busy     = w_md_busy;
  assign md_done     = w_md_done;
  assign stall_cnt   = r_stall_cnt;

  // State follows the falling edge used by the pipeline registers.
  always_ff @(negedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_md_cnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (md_start_ID && !w_stall) begin
            r_state  <= S_MD_BUSY;
            r_md_cnt <= md_div_ID ? DIV_LD : MULT_LD;
          end
        end
        S_MD_BUSY: begin
          if (r_md_cnt == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_md_cnt <= r_md_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: combinational vector table
// plus multi-cycle mult/div, reset and saturation sequences.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  Rs_ID, Rt_ID, Rt_EX;
  logic        uses_rt_ID, MemRead_EX;
  logic        branch_taken_ID, jump_ID;
  logic        md_start_ID, md_div_ID, hilo_read_ID;
  logic        pc_write, stall_IF_ID, flush_IF_ID, flush_ID_EX;
  logic        md_busy, md_done;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  pipe_hazard_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst),
    .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .uses_rt_ID(uses_rt_ID),
    .MemRead_EX(MemRead_EX), .Rt_EX(Rt_EX),
    .branch_taken_ID(branch_taken_ID), .jump_ID(jump_ID),
    .md_start_ID(md_start_ID), .md_div_ID(md_div_ID),
    .hilo_read_ID(hilo_read_ID),
    .pc_write(pc_write), .stall_IF_ID(stall_IF_ID),
    .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
    .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [4:0] rs, rt, rt_ex;
    logic       uses_rt, memread, br, jmp, hilo;
    logic       e_pc, e_st, e_fif, e_fex;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    Rs_ID = 0; Rt_ID = 0; Rt_EX = 0;
    uses_rt_ID = 0; MemRead_EX = 0;
    branch_taken_ID = 0; jump_ID = 0;
    md_start_ID = 0; md_div_ID = 0; hilo_read_ID = 0;
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string nm, input logic pc,
                         input logic st, input logic fif,
                         input logic fex);
    chk({nm, "_pc_write"}, 16'(pc_write), 16'(pc));
    chk({nm, "_stall_IF_ID"}, 16'(stall_IF_ID), 16'(st));
    chk({nm, "_flush_IF_ID"}, 16'(flush_IF_ID), 16'(fif));
    chk({nm, "_flush_ID_EX"}, 16'(flush_ID_EX), 16'(fex));
  endtask

  task automatic chk_rst(input string nm);
    chk_ctl(nm, 1'b0, 1'b0, 1'b1, 1'b1);
    chk({nm, "_md_busy"}, 16'(md_busy), 16'd0);
    chk({nm, "_md_done"}, 16'(md_done), 16'd0);
  endtask

  int n;

  initial begin
    //      rs  rt  rtex urt mr br jmp hilo  pc st fif fex
    vt[0] = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0,  1, 0, 0, 0};
    vt[1] = '{5'd5, 5'd0, 5'd5, 0, 1, 0, 0, 0,  0, 1, 0, 1};
    vt[2] = '{5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0,  1, 0, 0, 0};
    vt[3] = '{5'd3, 5'd7, 5'd7, 0, 1, 0, 0, 0,  1, 0, 0, 0};
    vt[4] = '{5'd3, 5'd7, 5'd7, 1, 1, 0, 0, 0,  0, 1, 0, 1};
    vt[5] = '{5'd5, 5'd0, 5'd5, 0, 0, 0, 0, 0,  1, 0, 0, 0};
    vt[6] = '{5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0,  1, 0, 1, 0};
    vt[7] = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0,  1, 0, 1, 0};
    vt[8] = '{5'd9, 5'd0, 5'd9, 0, 1, 1, 0, 0,  0, 1, 0, 1};
    vt[9] = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1,  1, 0, 0, 0};

    clr();
    rst = 1'b1;
    nxt();
    @(posedge clk);
    chk_rst("reset");
    nxt();
    rst = 1'b0;
    @(posedge clk);
    chk("post_reset_cnt", stall_cnt, 16'd0);
    chk("post_reset_busy", 16'(md_busy), 16'd0);
    chk_ctl("post_reset", 1'b1, 1'b0, 1'b0, 1'b0);
    nxt();

    for (int i = 0; i < 10; i++) begin
      clr();
      Rs_ID = vt[i].rs; Rt_ID = vt[i].rt; Rt_EX = vt[i].rt_ex;
      uses_rt_ID = vt[i].uses_rt; MemRead_EX = vt[i].memread;
      branch_taken_ID = vt[i].br; jump_ID = vt[i].jmp;
      hilo_read_ID = vt[i].hilo;
      @(posedge clk);
      chk_ctl($sformatf("vec%0d", i), vt[i].e_pc, vt[i].e_st,
              vt[i].e_fif, vt[i].e_fex);
      if (vt[i].e_st) exp_cnt++;
      nxt();
    end
    clr();
    @(posedge clk);
    chk("table_stall_cnt", stall_cnt, 16'(exp_cnt));
    nxt();

    // branch coincident with a load-use stall, then honoured
    MemRead_EX = 1; Rt_EX = 5'd4; Rs_ID = 5'd4; branch_taken_ID = 1;
    @(posedge clk);
    chk_ctl("br_stall", 1'b0, 1'b1, 1'b0, 1'b1);
    exp_cnt++;
    nxt();
    MemRead_EX = 0;
    @(posedge clk);
    chk_ctl("br_after", 1'b1, 1'b0, 1'b1, 1'b0);
    nxt();

    // mult followed by mflo
    clr();
    md_start_ID = 1;
    @(posedge clk);
    chk("mult_accept_pc", 16'(pc_write), 16'd1);
    nxt();
    md_start_ID = 0; hilo_read_ID = 1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      chk($sformatf("mult_busy%0d", k), 16'(md_busy), 16'd1);
      chk($sformatf("mult_stall%0d", k), 16'(stall_IF_ID), 16'd1);
      chk($sformatf("mult_done%0d", k), 16'(md_done), 16'(k == 4));
      exp_cnt++;
      nxt();
    end
    @(posedge clk);
    chk("mult_release_pc", 16'(pc_write), 16'd1);
    chk("mult_release_busy", 16'(md_busy), 16'd0);
    chk("mult_stall_cnt", stall_cnt, 16'(exp_cnt));
    nxt();

    // back-to-back divides
    clr();
    md_start_ID = 1; md_div_ID = 1;
    @(posedge clk);
    chk("div1_accept_pc", 16'(pc_write), 16'd1);
    nxt();
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      chk($sformatf("div_stall%0d", k), 16'(pc_write), 16'd0);
      if (k == 31 || k == 32)
        chk($sformatf("div_done%0d", k), 16'(md_done), 16'(k == 32));
      exp_cnt++;
      nxt();
    end
    @(posedge clk);
    chk("div2_accept_pc", 16'(pc_write), 16'd1);
    chk("div2_accept_busy", 16'(md_busy), 16'd0);
    nxt();
    md_start_ID = 0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      if (md_busy) n++;
      nxt();
    end
    chk("div2_busy_cycles", 16'(n), 16'd32);
    chk("div_stall_cnt", stall_cnt, 16'(exp_cnt));

    // reset while the divider is mid-operation (count at 17)
    clr();
    md_start_ID = 1; md_div_ID = 1;
    nxt();
    clr();
    for (int k = 0; k < 14; k++) nxt();
    @(posedge clk);
    chk("middiv_busy", 16'(md_busy), 16'd1);
    nxt();
    rst = 1;
    @(posedge clk);
    chk_rst("middiv_rst");
    nxt();
    rst = 0; hilo_read_ID = 1;
    @(posedge clk);
    chk("after_rst_busy", 16'(md_busy), 16'd0);
    chk("after_rst_cnt", stall_cnt, 16'd0);
    chk_ctl("after_rst", 1'b1, 1'b0, 1'b0, 1'b0);
    nxt();

    // saturation of the stall counter
    clr();
    MemRead_EX = 1; Rt_EX = 5'd5; Rs_ID = 5'd5;
    for (int k = 0; k < 65540; k++) nxt();
    @(posedge clk);
    chk("sat_cnt", stall_cnt, 16'hFFFF);
    chk("sat_pc", 16'(pc_write), 16'd0);
    for (int k = 0; k < 3; k++) nxt();
    @(posedge clk);
    chk("sat_hold", stall_cnt, 16'hFFFF);
    nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
